// File: rtl/memory_state.sv
// Memory-access stage of the pipelined OTTER core: issues data-memory requests
// over a REQ/ACK handshake, formats load data and fills the memory/writeback register.
module memory_state #(
  parameter int TIMEOUT = 255
) (
  input  logic        MEMORY_CLOCK,
  input  logic        MEMORY_RESET,
  input  logic        EXEC_VALID,
  input  logic [31:0] EXEC_PC_4,
  input  logic [31:0] EXEC_ALU_RESULT,
  input  logic [31:0] EXEC_RS2,
  input  logic [1:0]  EXEC_RF_WR_SEL,
  input  logic        EXEC_REGWRITE,
  input  logic        EXEC_MEMWRITE,
  input  logic        EXEC_MEMREAD2,
  input  logic [1:0]  EXEC_MEM_SIZE,
  input  logic        EXEC_MEM_UNSIGNED,
  output logic        MEM_STALL,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BE,
  input  logic        DMEM_ACK,
  input  logic [31:0] DMEM_RDATA,
  output logic        MEM_VALID,
  output logic        MEM_REGWRITE,
  output logic [31:0] MEM_PC_4,
  output logic [31:0] MEM_ALU_RESULT,
  output logic [31:0] MEM_DOUT2,
  output logic [1:0]  MEM_RF_WR_SEL,
  output logic        MEM_MISALIGN,
  output logic        MEM_BUS_ERR
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, pc4_q, pc4_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  size_q, size_d, sel_q, sel_d;
  logic        uns_q, uns_d, we_q, we_d, regwrite_q, regwrite_d;

  logic        wb_valid_q, wb_valid_d, wb_regwrite_q, wb_regwrite_d;
  logic [31:0] wb_pc4_q, wb_pc4_d, wb_alu_q, wb_alu_d, wb_dout_q, wb_dout_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic        misalign_q, misalign_d, bus_err_q, bus_err_d;

  logic        mem_op;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = a[0];
      default: misaligned = (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   byte_en = 4'b0001 << a;
      2'b01:   byte_en = 4'b0011 << a;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] rs2);
    case (size)
      2'b00:   store_data = {4{rs2[7:0]}};
      2'b01:   store_data = {2{rs2[15:0]}};
      default: store_data = rs2;
    endcase
  endfunction

  // Lane select uses the captured byte offset; alignment was already enforced.
  function automatic logic [31:0] load_data(input logic [1:0] size, input logic uns,
                                            input logic [1:0] a, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = rd[{a[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_data = {{24{b[7] & ~uns}}, b};
      2'b01:   load_data = {{16{h[15] & ~uns}}, h};
      default: load_data = rd;
    endcase
  endfunction

  assign mem_op = EXEC_MEMREAD2 | EXEC_MEMWRITE;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    pc4_d         = pc4_q;
    be_d          = be_q;
    size_d        = size_q;
    sel_d         = sel_q;
    uns_d         = uns_q;
    we_d          = we_q;
    regwrite_d    = regwrite_q;
    wb_valid_d    = 1'b0;
    wb_regwrite_d = wb_regwrite_q;
    wb_pc4_d      = wb_pc4_q;
    wb_alu_d      = wb_alu_q;
    wb_dout_d     = wb_dout_q;
    wb_sel_d      = wb_sel_q;
    misalign_d    = 1'b0;
    bus_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (EXEC_VALID) begin
          if (mem_op && !misaligned(EXEC_MEM_SIZE, EXEC_ALU_RESULT[1:0])) begin
            state_d    = ACCESS;
            cnt_d      = '0;
            addr_d     = EXEC_ALU_RESULT;
            size_d     = EXEC_MEM_SIZE;
            uns_d      = EXEC_MEM_UNSIGNED;
            we_d       = EXEC_MEMWRITE;
            regwrite_d = EXEC_REGWRITE;
            pc4_d      = EXEC_PC_4;
            sel_d      = EXEC_RF_WR_SEL;
            be_d       = byte_en(EXEC_MEM_SIZE, EXEC_ALU_RESULT[1:0]);
            wdata_d    = store_data(EXEC_MEM_SIZE, EXEC_RS2);
          end else begin
            // Plain ALU op, or a misaligned access retired without a request.
            wb_valid_d    = 1'b1;
            wb_regwrite_d = EXEC_REGWRITE & ~mem_op;
            wb_pc4_d      = EXEC_PC_4;
            wb_alu_d      = EXEC_ALU_RESULT;
            wb_dout_d     = '0;
            wb_sel_d      = EXEC_RF_WR_SEL;
            misalign_d    = mem_op;
          end
        end
      end
      ACCESS: begin
        // ACK takes priority over an expiring timeout in the same cycle.
        if (DMEM_ACK || cnt_q == TMO_LAST) begin
          state_d       = IDLE;
          wb_valid_d    = 1'b1;
          wb_regwrite_d = DMEM_ACK & regwrite_q;
          wb_pc4_d      = pc4_q;
          wb_alu_d      = addr_q;
          wb_sel_d      = sel_q;
          wb_dout_d     = (DMEM_ACK && !we_q) ? load_data(size_q, uns_q, addr_q[1:0], DMEM_RDATA)
                                              : '0;
          bus_err_d     = ~DMEM_ACK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MEMORY_CLOCK or negedge MEMORY_RESET) begin
    if (!MEMORY_RESET) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      pc4_q         <= '0;
      be_q          <= '0;
      size_q        <= '0;
      sel_q         <= '0;
      uns_q         <= 1'b0;
      we_q          <= 1'b0;
      regwrite_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_pc4_q      <= '0;
      wb_alu_q      <= '0;
      wb_dout_q     <= '0;
      wb_sel_q      <= '0;
      misalign_q    <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      pc4_q         <= pc4_d;
      be_q          <= be_d;
      size_q        <= size_d;
      sel_q         <= sel_d;
      uns_q         <= uns_d;
      we_q          <= we_d;
      regwrite_q    <= regwrite_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_pc4_q      <= wb_pc4_d;
      wb_alu_q      <= wb_alu_d;
      wb_dout_q     <= wb_dout_d;
      wb_sel_q      <= wb_sel_d;
      misalign_q    <= misalign_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign DMEM_REQ   = (state_q == ACCESS);
  assign MEM_STALL  = DMEM_REQ;
  assign DMEM_WE    = DMEM_REQ & we_q;
  assign DMEM_ADDR  = DMEM_REQ ? {addr_q[31:2], 2'b00} : '0;
  assign DMEM_BE    = DMEM_REQ ? be_q : '0;
  assign DMEM_WDATA = DMEM_REQ ? wdata_q : '0;

  assign MEM_VALID      = wb_valid_q;
  assign MEM_REGWRITE   = wb_regwrite_q;
  assign MEM_PC_4       = wb_pc4_q;
  assign MEM_ALU_RESULT = wb_alu_q;
  assign MEM_DOUT2      = wb_dout_q;
  assign MEM_RF_WR_SEL  = wb_sel_q;
  assign MEM_MISALIGN   = misalign_q;
  assign MEM_BUS_ERR    = bus_err_q;

endmodule

// File: doc/memory_state.md
# memory_state

Memory-access stage of the pipelined OTTER core. It takes the execute-register outputs (ALU result, rs2, PC+4, writeback controls), issues load/store requests to data memory over a REQ/ACK handshake, and formats load data. It captures the results into the memory/writeback pipeline register and stalls upstream stages while a memory access is outstanding.

## Interface
- TIMEOUT, 255: max cycles DMEM_REQ stays high without DMEM_ACK before the access is aborted (1..65535).
- MEMORY_CLOCK  in  1  stage clock; all state updates on rising edge.
- MEMORY_RESET  in  1  asynchronous, active-low reset.
- EXEC_VALID  in  1  execute register holds a valid instruction.
- EXEC_PC_4, EXEC_ALU_RESULT, EXEC_RS2  in  32 each  PC+4; ALU result (also the memory address); store data.
- EXEC_RF_WR_SEL  in  2  writeback mux select, passed through.
- EXEC_REGWRITE, EXEC_MEMWRITE, EXEC_MEMREAD2  in  1 each  writeback enable; store; load.
- EXEC_MEM_SIZE  in  2  00 byte, 01 half, 10 word (11 treated as word).
- EXEC_MEM_UNSIGNED  in  1  1 = zero-extend loads.
- MEM_STALL  out  1  upstream must hold EXEC_* stable.
- DMEM_REQ, DMEM_WE  out  1 each  request; 1 = write.
- DMEM_ADDR  out  32  word-aligned address (EXEC_ALU_RESULT with [1:0] = 0).
- DMEM_WDATA  out  32  store data replicated across lanes.
- DMEM_BE  out  4  byte enables.
- DMEM_ACK  in  1  access complete; DMEM_RDATA valid in the same cycle.
- DMEM_RDATA  in  32  read word.
- MEM_VALID, MEM_REGWRITE  out  1 each  writeback register contents valid; writeback enable.
- MEM_PC_4, MEM_ALU_RESULT, MEM_DOUT2  out  32 each  pass-throughs; formatted load data.
- MEM_RF_WR_SEL  out  2  pass-through.
- MEM_MISALIGN, MEM_BUS_ERR  out  1 each  one-cycle error pulses.

## Operation
- FSM states: IDLE and ACCESS.
- IDLE, EXEC_VALID=1, no memory op (MEMREAD2=MEMWRITE=0): the writeback register loads the pass-throughs, MEM_DOUT2=0, MEM_VALID=1.
- IDLE, EXEC_VALID=1, memory op, aligned: capture address, size, sign, controls and store data; go to ACCESS. The writeback register is not loaded.
- Alignment rules:
  - Half is misaligned when addr[0]=1.
  - Word is misaligned when addr[1:0]≠0.
- IDLE, EXEC_VALID=1, memory op, misaligned: no request is issued. The writeback register loads with MEM_REGWRITE=0 and MEM_VALID=1, and MEM_MISALIGN pulses.
- IDLE, EXEC_VALID=0: MEM_VALID=0 next cycle. The other writeback register fields hold.
- ACCESS: DMEM_REQ=1, and DMEM_ADDR/WE/BE/WDATA are held constant from registers. MEM_STALL=1 (combinational from the state).
- ACCESS, DMEM_ACK=1: the writeback register loads, MEM_VALID=1, and the FSM returns to IDLE.
  - For a load, MEM_DOUT2 = the selected lane, sign- or zero-extended.
  - For a store, MEM_DOUT2=0 and MEM_REGWRITE = captured value.
- Timeout counter: cleared on entry to ACCESS, incremented each ACCESS cycle without ACK.
  - When it reaches TIMEOUT: drop REQ, return to IDLE, MEM_BUS_ERR pulses.
  - The writeback register loads with MEM_REGWRITE=0 and MEM_VALID=1.
- Byte enables by size and addr[1:0]:
  - byte: 0001 << addr[1:0]
  - half: 0011 << addr[1:0]
  - word: 1111
- Store data: WDATA = {4{rs2[7:0]}} for byte, {2{rs2[15:0]}} for half, rs2 for word.
- Load lane select: byte → RDATA[8*addr[1:0] +: 8]; half → RDATA[16*addr[1] +: 16].
- Reads issue DMEM_WE=0 with BE set per size. Memory ignores BE on reads.
- DMEM_ACK while IDLE is ignored.

## Timing
- Reset (asynchronous, MEMORY_RESET=0):
  - Every output drops to 0 immediately, including DMEM_REQ and MEM_STALL mid-access.
  - The FSM enters IDLE and the counter clears.
  - After release, the first edge can accept an instruction.
- Non-memory op: MEM_* is valid 1 cycle after the accepting edge.
- Memory op accepted at edge N:
  - DMEM_REQ and MEM_STALL go high after edge N.
  - If ACK is sampled at edge N+k (k≥1), REQ and STALL drop after that edge, and MEM_* is valid from that edge.
  - Zero-wait memory (ACK tied high) costs 2 cycles per memory op.
- While MEM_STALL=1, EXEC_* changes are ignored. The instruction present in the ACK cycle is accepted on the next edge after STALL falls.
- ACK and timeout at the same edge: ACK wins (no MEM_BUS_ERR).
- MEM_MISALIGN and MEM_BUS_ERR are high for exactly one cycle, aligned with the MEM_VALID of the affected instruction.

## Test plan
- Reset mid-access (ACCESS, REQ=1), pull MEMORY_RESET low → REQ, STALL and MEM_VALID are 0 without waiting for a clock edge. After release, an ALU op is accepted on the first edge.
- Non-memory op: ALU_RESULT=0x1234, REGWRITE=1 → MEM_ALU_RESULT=0x1234, MEM_REGWRITE=1, MEM_VALID=1 one cycle later; MEM_STALL never asserted.
- Store byte to addr 0x103, rs2=0x000000A5, ACK after 3 cycles → DMEM_ADDR=0x100, BE=1000, WDATA=0xA5A5A5A5, WE=1. REQ is held 3 cycles with STALL=1.
- Load signed byte from addr 0x102 with RDATA=0x00800000 → MEM_DOUT2=0xFFFFFF80. The unsigned variant → 0x00000080.
- Load half from addr 0x101 → no DMEM_REQ, MEM_MISALIGN pulse, MEM_REGWRITE=0, MEM_VALID=1.
- TIMEOUT=4, load with ACK never asserted → REQ high for 4 cycles then drops, MEM_BUS_ERR pulse, MEM_REGWRITE=0. A back-to-back load with ACK tied high then completes in 2 cycles.
